// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch unit: fetch PC, imem req/ack, decode FIFO
//
// Owns the fetch PC, issues one outstanding word read at a time to
// instruction memory and buffers returned words for the decode stage.
// A redirect flushes the buffer and restarts fetch at the new PC.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   imem_req/addr     registered read request and word address to imem
//   imem_ack/rdata    one-cycle completion pulse and returned word
//   redirect_valid/pc branch/jump restart request and target PC
//   instr_valid/ready decode handshake on the buffer head
//   instr, instr_pc   head word and its PC (zero when empty)
//   opcode, func      instr[31:26] and instr[5:0]
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [5:0]  opcode,
  output logic [5:0]  func
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // IDLE: nothing outstanding; REQ: outstanding, data wanted;
  // DROP: outstanding, data belongs to a squashed path
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n, addr_n, pc_inc, redirect_word;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc    [DEPTH];
  logic          push, pop, flush;

  assign pc_inc        = fetch_pc + 32'd4;
  assign redirect_word = redirect_pc & ~32'h3;
  assign instr_valid   = (count != '0);
  assign pop           = instr_valid & instr_ready;

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    addr_n     = imem_addr;
    push       = 1'b0;
    flush      = 1'b0;

    // A redirect always wins the fetch PC and empties the buffer, whatever
    // the request state; the outstanding request is still waited out.
    if (redirect_valid) begin
      flush      = 1'b1;
      fetch_pc_n = redirect_word;
    end

    case (state)
      IDLE: begin
        if (!redirect_valid && (count < DEPTH_C)) begin
          state_n = REQ;
          addr_n  = fetch_pc;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          state_n = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_n = pc_inc;
          // Keep streaming only if the word just pushed leaves a free slot,
          // so a push can never land on a full buffer.
          if (((count + CNT_ONE) < DEPTH_C) || pop) begin
            addr_n = pc_inc;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DROP: begin
        if (imem_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_addr <= RESET_PC;
      imem_req  <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      imem_addr <= addr_n;
      imem_req  <= (state_n != IDLE);
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        if (push && !pop)      count <= count + CNT_ONE;
        else if (pop && !push) count <= count - CNT_ONE;
      end
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]    <= fetch_pc;
    end
  end

  assign instr    = instr_valid ? buf_instr[rd_ptr] : 32'd0;
  assign instr_pc = instr_valid ? buf_pc[rd_ptr]    : 32'd0;
  assign opcode   = instr[31:26];
  assign func     = instr[5:0];

endmodule
